load_store_unit: RTL

- RV32I load/store unit between the execute stage and data_mem.
- Accepts one memory op per handshake and computes the effective address (base + offset).
- Checks alignment and funct3 legality, sequences the read/write strobes into data_mem, and returns load results to writeback.
- Single outstanding access; the pipeline stalls on req_ready low.

---
 rtl/rv32_lsu_pkg.sv | 33 +++
 rtl/lsu_addr_check.sv | 46 ++++
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared encodings for the RV32I load/store unit: funct3 codes, access sizes,
// fault causes and FSM states.
package rv32_lsu_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [1:0] FAULT_NONE           = 2'b00;
  localparam logic [1:0] FAULT_LOAD_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_STORE_MISALIGN = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL        = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_addr_check.sv
// Decodes funct3 into access size/signedness and classifies the op as legal,
// illegal or misaligned. Illegal always wins over misaligned.
module lsu_addr_check
  import rv32_lsu_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] funct3,
  input  logic       is_load,
  input  logic       is_store,
  output logic [1:0] mem_size,
  output logic       is_signed,
  output logic [1:0] fault_cause
);

  logic illegal;
  logic misaligned;

  always_comb begin
    mem_size = MEM_SIZE_B;
    illegal  = (is_load == is_store);
    if (is_store) begin
      case (funct3)
        F3_SB:   mem_size = MEM_SIZE_B;
        F3_SH:   mem_size = MEM_SIZE_H;
        F3_SW:   mem_size = MEM_SIZE_W;
        default: illegal  = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: mem_size = MEM_SIZE_B;
        F3_LH, F3_LHU: mem_size = MEM_SIZE_H;
        F3_LW:         mem_size = MEM_SIZE_W;
        default:       illegal  = 1'b1;
      endcase
    end
  end

  assign is_signed  = ~funct3[2];
  assign misaligned = ((mem_size == MEM_SIZE_H) && addr_lo[0]) ||
                      ((mem_size == MEM_SIZE_W) && (addr_lo != 2'b00));

  assign fault_cause = illegal    ? FAULT_ILLEGAL :
                       misaligned ? (is_load ? FAULT_LOAD_MISALIGN : FAULT_STORE_MISALIGN) :
                                    FAULT_NONE;

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, sequences data_mem strobes and
// returns load data to writeback. Handshake: req accepted when req_valid & req_ready at clk.
module load_store_unit
  import rv32_lsu_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_offset,
  input  logic [XLEN-1:0] req_store_data,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_size,
  output logic            mem_is_signed,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            store_done,
  output logic            fault_valid,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] fault_addr,
  output logic [2:0]      dbg_state
);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [4:0]       rd_q, rd_d;
  logic             flushed_q, flushed_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             wb_pend_q, wb_pend_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             store_done_q, store_done_d;
  logic             fault_valid_q, fault_valid_d;
  logic [1:0]       fault_cause_q, fault_cause_d;
  logic [XLEN-1:0]  fault_addr_q, fault_addr_d;

  logic [XLEN-1:0]  eff_addr;
  logic [1:0]       chk_size;
  logic             chk_signed;
  logic [1:0]       chk_cause;

  assign eff_addr = req_base + req_offset;

  lsu_addr_check u_addr_check (
    .addr_lo     (eff_addr[1:0]),
    .funct3      (req_funct3),
    .is_load     (req_is_load),
    .is_store    (req_is_store),
    .mem_size    (chk_size),
    .is_signed   (chk_signed),
    .fault_cause (chk_cause)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    signed_d      = signed_q;
    rd_d          = rd_q;
    flushed_d     = flushed_q;
    wb_data_d     = wb_data_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    wb_pend_d     = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    store_done_d  = 1'b0;
    fault_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d    = eff_addr;
          size_d    = chk_size;
          signed_d  = chk_signed;
          wdata_d   = req_store_data;
          rd_d      = req_rd;
          flushed_d = 1'b0;
          if (chk_cause != FAULT_NONE) begin
            state_d       = ST_FAULT;
            fault_valid_d = 1'b1;
            fault_cause_d = chk_cause;
            fault_addr_d  = eff_addr;
          end else if (req_is_store) begin
            state_d      = ST_STORE;
            mem_write_d  = 1'b1;
            store_done_d = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            mem_read_d = 1'b1;
            cnt_d      = CNT_W'(READ_LAT - 1);
          end
        end
      end
      ST_LOAD: begin
        // A flush only poisons the writeback; the read sequence still runs to completion.
        if (flush) flushed_d = 1'b1;
        if (cnt_q == '0) begin
          state_d   = ST_RESP;
          wb_data_d = mem_read_data;
          wb_pend_d = (rd_q != 5'd0) && !flushed_q && !flush;
        end else begin
          cnt_d      = cnt_q - 1'b1;
          mem_read_d = 1'b1;
        end
      end
      ST_STORE: state_d = ST_IDLE;
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      rd_q          <= '0;
      flushed_q     <= 1'b0;
      wb_data_q     <= '0;
      wb_pend_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      store_done_q  <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      rd_q          <= rd_d;
      flushed_q     <= flushed_d;
      wb_data_q     <= wb_data_d;
      wb_pend_q     <= wb_pend_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      store_done_q  <= store_done_d;
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_size       = size_q;
  assign mem_is_signed  = signed_q;
  // Flush arriving in the RESP cycle itself must still cancel the pulse.
  assign wb_valid       = wb_pend_q & ~flush;
  assign wb_rd          = rd_q;
  assign wb_data        = wb_data_q;
  assign store_done     = store_done_q;
  assign fault_valid    = fault_valid_q;
  assign fault_cause    = fault_cause_q;
  assign fault_addr     = fault_addr_q;
  assign dbg_state      = state_q;

endmodule
